// File: rtl/seq_hex_divider.sv
// Sequential restoring divider (DVD_W-bit dividend / DVS_W-bit divisor), one quotient bit per clock,
// with start/busy/done handshake. Define SEVEN_SEG_EN to build the HEX0..HEX2 glyph decoders.

module seq_hex_divider_seg7 (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  // Active-low segments, bit order g..a.
  always_comb begin
    unique case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
  end
endmodule

module seq_hex_divider #(
  parameter int DVD_W = 8,
  parameter int DVS_W = 4
) (
  input  logic             CLOCK_50,
  input  logic             RST,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic [DVD_W-1:0] quotient,
  output logic [DVS_W-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             dbz,
  output logic [6:0]       HEX0,
  output logic [6:0]       HEX1,
  output logic [6:0]       HEX2
);

  localparam int CNT_W = (DVD_W > 2) ? $clog2(DVD_W) : 1;

  generate
    if (DVD_W < 2 || DVD_W > 8) begin : g_bad_dvd
      $error("seq_hex_divider: DVD_W must be 2..8");
    end
    if (DVS_W < 1 || DVS_W > 4) begin : g_bad_dvs
      $error("seq_hex_divider: DVS_W must be 1..4");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [DVD_W-1:0] sreg;
  logic [DVS_W-1:0] dvs;
  logic [DVS_W-1:0] prem;
  logic [CNT_W-1:0] cnt;

  logic [DVS_W:0]   prem_shift;
  logic             ge;
  logic [DVS_W-1:0] prem_nxt;
  logic [DVD_W-1:0] sreg_nxt;
  logic             last_iter;

  // Partial remainder is widened by one bit so the compare against the divisor never overflows.
  always_comb begin
    prem_shift = {prem, sreg[DVD_W-1]};
    ge         = (prem_shift >= {1'b0, dvs});
    prem_nxt   = ge ? DVS_W'(prem_shift - {1'b0, dvs}) : prem_shift[DVS_W-1:0];
    sreg_nxt   = {sreg[DVD_W-2:0], ge};
    last_iter  = (cnt == CNT_W'(DVD_W - 1));
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: next-state is defaulted first so no path through the case leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start) state_nxt = S_CALC;
      S_CALC:  if (last_iter) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state == S_CALC);
  assign done = (state == S_DONE);

  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      sreg      <= '0;
      dvs       <= '0;
      prem      <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      dbz       <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            sreg <= dividend;
            dvs  <= divisor;
            prem <= '0;
            cnt  <= '0;
          end
        end
        S_CALC: begin
          sreg <= sreg_nxt;
          prem <= prem_nxt;
          cnt  <= cnt + CNT_W'(1);
          // Results land on the final iteration edge, i.e. on entry to DONE.
          if (last_iter) begin
            if (dvs == '0) begin
              quotient  <= '1;
              remainder <= '1;
              dbz       <= 1'b1;
            end else begin
              quotient  <= sreg_nxt;
              remainder <= prem_nxt;
              dbz       <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SEVEN_SEG_EN
  logic [7:0] q_ext;
  logic [3:0] r_ext;

  assign q_ext = 8'(quotient);
  assign r_ext = 4'(remainder);

  seq_hex_divider_seg7 u_hex0 (.nibble(q_ext[3:0]), .seg(HEX0));
  seq_hex_divider_seg7 u_hex1 (.nibble(q_ext[7:4]), .seg(HEX1));
  seq_hex_divider_seg7 u_hex2 (.nibble(r_ext),      .seg(HEX2));
`else
  assign HEX0 = 7'h7F;
  assign HEX1 = 7'h7F;
  assign HEX2 = 7'h7F;
`endif

endmodule

// File: tb/tb_seq_hex_divider.sv
// Self-checking bench for seq_hex_divider: table of directed divisions plus multi-cycle corner sequences.

module tb_seq_hex_divider;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       busy, done, dbz;
  logic [6:0] hex0, hex1, hex2;

  int n_checks = 0;
  int n_fails  = 0;

  always #10 clk = ~clk;

  seq_hex_divider dut (
    .CLOCK_50 (clk),
    .RST      (rst),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .quotient (quotient),
    .remainder(remainder),
    .busy     (busy),
    .done     (done),
    .dbz      (dbz),
    .HEX0     (hex0),
    .HEX1     (hex1),
    .HEX2     (hex2)
  );

  typedef struct {
    logic [7:0] dvd;
    logic [3:0] dvs;
    logic [7:0] q;
    logic [3:0] r;
    logic       z;
    logic [6:0] h0;
    logic [6:0] h1;
    logic [6:0] h2;
  } vec_t;

  function automatic logic [6:0] exp_hex(input logic [6:0] glyph);
`ifdef SEVEN_SEG_EN
    return glyph;
`else
    return 7'h7F;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Pulses start for one edge, then counts busy cycles until done (bounded).
  task automatic run_op(input logic [7:0] a, input logic [3:0] b,
                        output int busy_cycles, output bit got_done);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    busy_cycles = 0;
    got_done    = 1'b0;
    for (int i = 0; i < 20 && !got_done; i++) begin
      @(negedge clk);
      if (done) got_done = 1'b1;
      else if (busy) busy_cycles++;
    end
  endtask

  vec_t vecs[6];
  int   bc;
  bit   gd;
  int   n_done;
  int   last_done;
  logic [7:0] cap_q;
  logic [3:0] cap_r;

  initial begin
    vecs[0] = '{8'd200, 4'd7, 8'h1C, 4'h4, 1'b0, 7'h46, 7'h79, 7'h19};
    vecs[1] = '{8'd255, 4'd1, 8'hFF, 4'h0, 1'b0, 7'h0E, 7'h0E, 7'h40};
    vecs[2] = '{8'd5,   4'd9, 8'h00, 4'h5, 1'b0, 7'h40, 7'h40, 7'h12};
    vecs[3] = '{8'd100, 4'd0, 8'hFF, 4'hF, 1'b1, 7'h0E, 7'h0E, 7'h0E};
    vecs[4] = '{8'd8,   4'd2, 8'h04, 4'h0, 1'b0, 7'h19, 7'h40, 7'h40};
    vecs[5] = '{8'd81,  4'd9, 8'h09, 4'h0, 1'b0, 7'h10, 7'h40, 7'h40};

    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    check("reset quotient",  32'(quotient),  32'h0);
    check("reset remainder", 32'(remainder), 32'h0);
    check("reset busy",      32'(busy),      32'h0);
    check("reset done",      32'(done),      32'h0);
    check("reset dbz",       32'(dbz),       32'h0);
    check("reset HEX0",      32'(hex0),      32'(exp_hex(7'h40)));
    check("reset HEX2",      32'(hex2),      32'(exp_hex(7'h40)));
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      run_op(vecs[i].dvd, vecs[i].dvs, bc, gd);
      check($sformatf("v%0d done seen", i), 32'(gd), 32'h1);
      check($sformatf("v%0d busy cycles", i), 32'(bc), 32'd8);
      check($sformatf("v%0d quotient", i), 32'(quotient), 32'(vecs[i].q));
      check($sformatf("v%0d remainder", i), 32'(remainder), 32'(vecs[i].r));
      check($sformatf("v%0d dbz", i), 32'(dbz), 32'(vecs[i].z));
      check($sformatf("v%0d HEX0", i), 32'(hex0), 32'(exp_hex(vecs[i].h0)));
      check($sformatf("v%0d HEX1", i), 32'(hex1), 32'(exp_hex(vecs[i].h1)));
      check($sformatf("v%0d HEX2", i), 32'(hex2), 32'(exp_hex(vecs[i].h2)));
      @(negedge clk);
      check($sformatf("v%0d done pulse width", i), 32'(done), 32'h0);
      check($sformatf("v%0d result hold", i), 32'(quotient), 32'(vecs[i].q));
    end

    // start during CALC is ignored and operand changes do not disturb the running division.
    @(negedge clk);
    dividend = 8'd200; divisor = 4'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n_done = 0; cap_q = '0; cap_r = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 2) begin
        start = 1'b1; dividend = 8'd15; divisor = 4'd3;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        n_done++;
        cap_q = quotient;
        cap_r = remainder;
      end
    end
    check("ignored start done count", 32'(n_done), 32'd1);
    check("ignored start quotient",   32'(cap_q),  32'h1C);
    check("ignored start remainder",  32'(cap_r),  32'h4);

    // Reset in the middle of CALC aborts asynchronously without a done pulse.
    @(negedge clk);
    dividend = 8'd200; divisor = 4'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre-abort busy", 32'(busy), 32'h1);
    #3 rst = 1'b1;
    #1;
    check("abort busy",      32'(busy),      32'h0);
    check("abort quotient",  32'(quotient),  32'h0);
    check("abort remainder", 32'(remainder), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("abort no done", 32'(n_done), 32'd0);
    run_op(8'd81, 4'd9, bc, gd);
    check("post-reset done seen", 32'(gd),        32'h1);
    check("post-reset quotient",  32'(quotient),  32'h09);
    check("post-reset remainder", 32'(remainder), 32'h0);

    // start held high: a new operation every DVD_W+2 cycles.
    repeat (2) @(negedge clk);
    dividend = 8'd240; divisor = 4'd15; start = 1'b1;
    n_done = 0; last_done = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        n_done++;
        check($sformatf("held q #%0d", n_done), 32'(quotient),  32'h10);
        check($sformatf("held r #%0d", n_done), 32'(remainder), 32'h0);
        if (last_done >= 0)
          check($sformatf("held interval #%0d", n_done), 32'(i - last_done), 32'd10);
        else
          check("held first latency", 32'(i), 32'd8);
        last_done = i;
      end
    end
    start = 1'b0;
    check("held done count", 32'(n_done), 32'd4);
    repeat (12) @(negedge clk);
    check("final idle busy", 32'(busy), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/seq_hex_divider.md
Name: seq_hex_divider

Overview:
- Sequential restoring divider: the inverse operation of the team's combinational 4x4 hex multiplier.
- Divides an 8-bit dividend by a 4-bit divisor, one quotient bit per clock, behind a start/busy/done handshake.
- Drives quotient and remainder onto the board's seven-segment displays.
- Sits at board top level next to the multiplier; switches supply operands, the display shows results.

Parameters:
- DVD_W, 8, dividend and quotient width; iteration count equals DVD_W; legal range 2..8.
- DVS_W, 4, divisor and remainder width; legal range 1..4.

Ports:
- CLOCK_50  in  1  system clock; all state updates on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- dividend  in  DVD_W  numerator; captured on accepted start.
- divisor  in  DVS_W  denominator; captured on accepted start.
- quotient  out  DVD_W  registered result.
- remainder  out  DVS_W  registered result.
- busy  out  1  high while iterating.
- done  out  1  one-cycle pulse when results update.
- dbz  out  1  divide-by-zero flag for the last operation.
- HEX0  out  7  quotient[3:0] glyph, active-low segments [6:0]=g..a.
- HEX1  out  7  quotient[7:4] glyph, active-low.
- HEX2  out  7  remainder glyph, active-low.

Behaviour:
- Reset (async, any state): state=IDLE. Outputs: quotient=0, remainder=0, busy=0, done=0, dbz=0. Internal registers cleared. HEX0/HEX1/HEX2 show "0" (7'h40) when SEVEN_SEG_EN is defined.
- States: IDLE, CALC, DONE.
- IDLE:
  - start=1 at an edge captures dividend into the shift register, captures divisor, clears the (DVS_W+1)-bit partial remainder and the iteration counter, and moves to CALC.
  - busy rises the same edge.
- CALC, each edge:
  - Partial remainder = {prem[DVS_W-1:0], msb of shift register}; shift the register left.
  - If prem >= divisor: subtract divisor and shift in quotient bit 1; else shift in 0.
  - The partial remainder is DVS_W+1 bits so the compare never overflows.
  - Counter increments; after DVD_W iterations, move to DONE.
- CALC is exactly DVD_W cycles. busy is high for exactly DVD_W cycles (8 by default).
- DONE (one cycle): quotient, remainder and dbz update on entry; done=1 for this single cycle; busy=0. Next edge returns to IDLE.
- Latency: start accepted at edge k gives done high in the cycle after edge k+DVD_W. With defaults, results are valid from edge k+8.
- Results hold until the next done. They are not cleared by a new start.
- start while CALC or DONE is ignored; it is not queued.
- start held high continuously: a new operation is accepted at each return to IDLE, every DVD_W+2 cycles.
- Operand inputs may change freely after capture; the running operation is unaffected.
- divisor==0: the algorithm runs normally for DVD_W cycles. The result is forced to quotient=all ones, remainder=all ones, dbz=1. dbz clears on the next nonzero-divisor result.
- Reset mid-CALC: aborts immediately, with no done pulse; outputs return to reset values.
- Display:
  - Quotient and remainder are zero-extended to 8 bits and 4 bits respectively.
  - Glyphs are the standard hex set 0-9, A, b, C, d, E, F.
  - Encoding is combinational from the registered outputs.

Optional Feature:
- SEVEN_SEG_EN defined: hex glyph decoders are instantiated and HEX0/HEX1/HEX2 follow quotient/remainder as above.
- SEVEN_SEG_EN undefined: decoders are not built and HEX0/HEX1/HEX2 are tied to 7'h7F (all segments off).
- Divider function, handshake and timing are identical either way.

Test Plan:
- 200/7, start pulsed one cycle -> busy high for 8 cycles, then done pulse; quotient=8'h1C, remainder=4'h4, dbz=0; HEX1=7'h79, HEX0=7'h46, HEX2=7'h19.
- 255/1 -> quotient=8'hFF, remainder=0; HEX1=HEX0=7'h0E, HEX2=7'h40. 5/9 -> quotient=0, remainder=5, HEX2=7'h12.
- 100/0 -> quotient=8'hFF, remainder=4'hF, dbz=1. Follow with 8/2 -> quotient=4, remainder=0, dbz=0.
- start 200/7, then at cycle 3 of CALC pulse start with 15/3 and change operands -> single done; result 8'h1C r4; 15/3 is never computed.
- Assert RST during CALC cycle 5 -> busy=0, quotient=0, remainder=0 asynchronously; no done pulse. After release, 81/9 -> quotient=9, remainder=0.
- start held high for 40 cycles with 240/15 -> done pulses every 10 cycles, each giving quotient=8'h10, remainder=0. Build without SEVEN_SEG_EN -> all HEX=7'h7F and identical quotient/remainder timing.
